// File: rtl/rtc_match_int_array_if.sv
// Bus bundle for the RTC match/interrupt channel array.
// The master side drives the counter, controls and writes; the slave side returns the match registers and status.
interface rtc_match_int_array_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    logic [CNT_W-1:0]        Count;
    logic [NUM_CH-1:0]       ChEn;
    logic [NUM_CH-1:0]       Periodic;
    logic [NUM_CH-1:0]       IntMask;
    logic [NUM_CH-1:0]       IntClr;
    logic [NUM_CH-1:0]       MatchWr;
    logic [NUM_CH-1:0]       PeriodWr;
    logic [CNT_W-1:0]        WrData;
    logic [NUM_CH*CNT_W-1:0] MatchData;
    logic [NUM_CH-1:0]       RawStatus;
    logic [NUM_CH-1:0]       Overrun;
    logic [NUM_CH-1:0]       MaskStatus;
    logic                    IntrOut;

    modport master (
        output Count, ChEn, Periodic, IntMask, IntClr, MatchWr, PeriodWr, WrData,
        input  MatchData, RawStatus, Overrun, MaskStatus, IntrOut
    );

    modport slave (
        input  Count, ChEn, Periodic, IntMask, IntClr, MatchWr, PeriodWr, WrData,
        output MatchData, RawStatus, Overrun, MaskStatus, IntrOut
    );
endinterface

// File: rtl/rtc_match_int_array.sv
// Array of RTC compare channels: each channel raises a sticky interrupt when the counter
// first equals its match value, and can optionally advance its match value by a period.
module rtc_match_int_array #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int PERIODIC_EN = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    rtc_match_int_array_if.slave  bus
);
    localparam bit ReloadEn = (PERIODIC_EN != 0);

    logic [CNT_W-1:0]  match_q  [NUM_CH];
    logic [CNT_W-1:0]  match_d  [NUM_CH];
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [NUM_CH-1:0] hitDly_q, hitDly_d;
    logic [NUM_CH-1:0] rawStatus_q, rawStatus_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic [NUM_CH-1:0] hit, evt, reload;

    // An event is the rising edge of equality, so a counter parked on the match value fires once.
    // Events beat a coincident clear; a register write beats a coincident reload.
    always_comb begin
        hit         = '0;
        evt         = '0;
        reload      = '0;
        hitDly_d    = hitDly_q;
        rawStatus_d = rawStatus_q;
        overrun_d   = overrun_q;
        match_d     = match_q;
        period_d    = period_q;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i]         = bus.ChEn[i] && (bus.Count == match_q[i]);
            evt[i]         = hit[i] && !hitDly_q[i];
            hitDly_d[i]    = hit[i];
            rawStatus_d[i] = evt[i] | (rawStatus_q[i] & ~bus.IntClr[i]);
            overrun_d[i]   = ~bus.IntClr[i] & (overrun_q[i] | (evt[i] & rawStatus_q[i]));
            reload[i]      = ReloadEn && bus.Periodic[i] && evt[i] && (period_q[i] != '0);
            if (bus.MatchWr[i]) begin
                match_d[i] = bus.WrData;
            end else if (reload[i]) begin
                match_d[i] = match_q[i] + period_q[i];
            end
            if (bus.PeriodWr[i]) begin
                period_d[i] = bus.WrData;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            hitDly_q    <= '0;
            rawStatus_q <= '0;
            overrun_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                match_q[i]  <= '0;
                period_q[i] <= '0;
            end
        end else begin
            hitDly_q    <= hitDly_d;
            rawStatus_q <= rawStatus_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < NUM_CH; i++) begin
                match_q[i]  <= match_d[i];
                period_q[i] <= period_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gMatchOut
        assign bus.MatchData[g*CNT_W +: CNT_W] = match_q[g];
    end

    assign bus.RawStatus  = rawStatus_q;
    assign bus.Overrun    = overrun_q;
    assign bus.MaskStatus = rawStatus_q & bus.IntMask;
    assign bus.IntrOut    = |(rawStatus_q & bus.IntMask);
endmodule
